// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-granular arbiter sharing one uart_tx serializer
// Owner keeps the serializer until a byte flagged last completes or it stalls past the timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int PACK_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 8680
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*PACK_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_start,
  output logic [PACK_SIZE-1:0]         tx_data,
  input  logic                         tx_active,
  input  logic                         tx_done,
  output logic                         grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         timeout_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] STALL_LIMIT = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] STALL_MAX   = '1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [PACK_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 last_r_q, last_r_d;
  logic [CNT_W-1:0]     stall_q, stall_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      cand;
  logic                 any_valid;
  logic                 handshake;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      last_r_q      <= 1'b0;
      stall_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      last_grant_q  <= last_grant_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      last_r_q      <= last_r_d;
      stall_q       <= stall_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Scan downward so the nearest valid requester above last_grant is the final write.
  always_comb begin
    winner    = last_grant_q;
    cand      = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  assign handshake = req_ready[grant_id_q] && req_valid[grant_id_q];

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    last_grant_d  = last_grant_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    last_r_d      = last_r_q;
    stall_d       = stall_q;
    timeout_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_d = '0;
        if (any_valid) begin
          grant_id_d    = winner;
          grant_valid_d = 1'b1;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          tx_data_d  = req_data[grant_id_q*PACK_SIZE +: PACK_SIZE];
          tx_start_d = 1'b1;
          last_r_d   = req_last[grant_id_q];
          stall_d    = '0;
          state_d    = WAIT;
        end else if (TIMEOUT_CYCLES > 0 && stall_q == STALL_LIMIT) begin
          timeout_err_d = 1'b1;
          grant_valid_d = 1'b0;
          last_grant_d  = grant_id_q;
          state_d       = IDLE;
        end else if (stall_q != STALL_MAX) begin
          stall_d = stall_q + 1'b1;
        end
      end
      WAIT: begin
        // A done coincident with our own start strobe belongs to the previous byte.
        if (tx_done && !tx_start_q) begin
          stall_d = '0;
          if (last_r_q) begin
            grant_valid_d = 1'b0;
            last_grant_d  = grant_id_q;
            state_d       = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == SEND && !tx_active) req_ready[grant_id_q] = 1'b1;
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
// Requesters are byte queues; expected transmit order comes from a message-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 20;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [W-1:0]   tx_data;
  logic           tx_active = 1'b0;
  logic           tx_done = 1'b0;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic           timeout_err;

  uart_tx_arbiter #(.NUM_REQ(N), .PACK_SIZE(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active),
    .tx_done(tx_done), .grant_valid(grant_valid), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] id; logic last; logic [7:0] data; } ent_t;
  typedef struct packed { logic [1:0] id; logic [7:0] data; } xfer_t;

  ent_t  pend[$];
  xfer_t exp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, s_cyc = 0, gap = 0, last_done_cyc = 0, n_starts = 0, ser_cnt = 0, model_last = N - 1;
  bit force_active = 0, ser_rand = 0, check_stream = 0, check_gap = 0, check_fall = 0;
  logic [N-1:0] s_hs = '0, s_ready = '0, prev_hs = '0;
  logic s_start = 0, s_done = 0, s_gv = 0, s_to = 0, prev_start = 0, prev_gv = 0;
  logic [W-1:0] s_data = '0, start_data = '0;
  logic [1:0] s_gid = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int head_of(input int id);
    for (int j = 0; j < pend.size(); j++) if (int'(pend[j].id) == id) return j;
    return -1;
  endfunction

  task automatic add_byte(input int id, input logic [7:0] data, input logic last);
    ent_t e;
    e.id = id[1:0]; e.last = last; e.data = data;
    pend.push_back(e);
  endtask

  task automatic drive_inputs();
    int h;
    for (int i = 0; i < N; i++) begin
      h = head_of(i);
      req_valid[i]       = (h >= 0);
      req_last[i]        = (h >= 0) ? pend[h].last : 1'b0;
      req_data[i*W +: W] = (h >= 0) ? pend[h].data : 8'h00;
    end
    tx_active = force_active || (ser_cnt > 0);
    tx_done   = (ser_cnt == 1);
  endtask

  // Whole messages leave in round-robin order starting after the previous owner.
  task automatic build_expected();
    ent_t  tmp[$];
    xfer_t x;
    int ptr, found, j, c;
    bit more, in_msg;
    tmp  = pend;
    ptr  = model_last;
    more = 1;
    while (more) begin
      found = -1;
      for (int k = 1; k <= N; k++) begin
        c = (ptr + k) % N;
        if (found < 0)
          for (int m = 0; m < tmp.size(); m++) if (int'(tmp[m].id) == c) found = c;
      end
      if (found < 0) more = 0;
      else begin
        in_msg = 1;
        while (in_msg) begin
          j = -1;
          for (int m = tmp.size() - 1; m >= 0; m--) if (int'(tmp[m].id) == found) j = m;
          if (j < 0) in_msg = 0;
          else begin
            x.id = found[1:0]; x.data = tmp[j].data;
            exp_q.push_back(x);
            in_msg = !tmp[j].last;
            tmp.delete(j);
          end
        end
        ptr = found;
      end
    end
    model_last = ptr;
  endtask

  task automatic tick();
    xfer_t e;
    int h;
    @(negedge clk);
    s_cyc = cyc;
    s_hs = req_valid & req_ready; s_ready = req_ready;
    s_start = tx_start; s_data = tx_data; s_gv = grant_valid; s_gid = grant_id;
    s_to = timeout_err; s_done = tx_done;
    if (s_start) begin
      check("start_single_cycle", prev_start, 0);
      start_data = s_data;
      n_starts++;
      if (check_stream) begin
        if (exp_q.size() == 0) check("stream_unexpected_byte", s_data, 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          check("stream_grant_id", s_gid, e.id);
          check("stream_tx_data", s_data, e.data);
        end
      end
    end
    if ((|prev_hs) || s_start) check("start_follows_handshake", s_start, |prev_hs);
    if (s_done && check_stream) check("tx_data_held", s_data, start_data);
    if (s_ready != '0) check("ready_only_owner", s_ready, 32'(4'b0001 << s_gid));
    if (s_done) last_done_cyc = s_cyc;
    if (check_fall && prev_gv && !s_gv) check("grant_drop_after_done", s_cyc - last_done_cyc, 1);
    if (!s_gv) gap++;
    else begin
      if (check_gap && gap > 0) check("idle_gap_between_grants", gap, 1);
      gap = 0;
    end
    prev_hs = s_hs; prev_start = s_start; prev_gv = s_gv;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (s_hs[i]) begin
      h = head_of(i);
      if (h >= 0) pend.delete(h);
    end
    if (s_start) ser_cnt = ser_rand ? int'($urandom_range(12, 2)) : 10;
    else if (ser_cnt > 0) ser_cnt--;
    drive_inputs();
    cyc++;
  endtask

  function automatic bit seen(input int what);
    case (what)
      0: return s_gv;
      1: return s_done;
      2: return s_to;
      default: return s_start;
    endcase
  endfunction

  task automatic wait_for(input int what, input int budget, input string tag);
    int n = 0;
    tick();
    while (!seen(what) && n < budget) begin tick(); n++; end
    check(tag, seen(what), 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    tick();
    while ((pend.size() != 0 || ser_cnt != 0 || s_gv) && n < budget) begin tick(); n++; end
    check("drain_complete", n < budget, 1);
    tick(); tick();
    check("expected_stream_consumed", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    ser_cnt = 0; model_last = N - 1; gap = 0;
    prev_hs = '0; prev_start = 0; prev_gv = 0;
    drive_inputs();
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_req_ready"}, s_ready, 0);
    check({phase, "_tx_start"}, s_start, 0);
    check({phase, "_tx_data"}, s_data, 0);
    check({phase, "_grant_valid"}, s_gv, 0);
    check({phase, "_grant_id"}, s_gid, 0);
    check({phase, "_timeout_err"}, s_to, 0);
  endtask

  initial begin
    int d, n0, id, len;

    do_reset();
    check_reset_outputs("reset");

    // Single two-byte message from requester 2.
    check_stream = 1; check_gap = 1; check_fall = 1; gap = 0;
    n0 = n_starts;
    add_byte(2, 8'h48, 1'b0);
    add_byte(2, 8'h69, 1'b1);
    build_expected();
    drive_inputs();
    drain(300);
    check("single_msg_start_count", n_starts - n0, 2);

    // Contention from reset: 0, 1 and 3 each hold a two-byte message.
    for (int r = 0; r < N; r++) if (r != 2) begin
      add_byte(r, 8'($urandom), 1'b0);
      add_byte(r, 8'($urandom), 1'b1);
    end
    do_reset();
    build_expected();
    drain(400);

    // Wrap-around: last owner was 3, so 0 beats 3, then 3 follows.
    gap = 0;
    add_byte(3, 8'hD3, 1'b0);
    add_byte(3, 8'hE3, 1'b1);
    add_byte(0, 8'hA0, 1'b0);
    add_byte(0, 8'hB0, 1'b1);
    build_expected();
    drive_inputs();
    drain(400);

    // Busy serializer holds off ready; ready returns in the cycle tx_active falls.
    gap = 0;
    force_active = 1;
    add_byte(1, 8'h77, 1'b1);
    build_expected();
    drive_inputs();
    wait_for(0, 10, "busy_grant_seen");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("busy_ready_low", s_ready, 0);
      check("busy_no_start", s_start, 0);
    end
    force_active = 0;
    drive_inputs();
    tick();
    check("busy_ready_rises", s_ready, 4'b0010);
    drain(200);

    // Mid-message stall: requester 1 sends 0xAA without last and goes quiet.
    check_fall = 0;
    add_byte(1, 8'hAA, 1'b0);
    add_byte(2, 8'h55, 1'b1);
    do_reset();
    exp_q.push_back(xfer_t'({2'd1, 8'hAA}));
    exp_q.push_back(xfer_t'({2'd2, 8'h55}));
    model_last = 2;
    wait_for(1, 40, "timeout_first_done_seen");
    d = s_cyc;
    wait_for(2, 40, "timeout_pulse_seen");
    check("timeout_latency_from_send", s_cyc - d, 21);
    check("timeout_grant_dropped", s_gv, 0);
    tick();
    check("timeout_single_pulse", s_to, 0);
    check("timeout_regrant_valid", s_gv, 1);
    check("timeout_regrant_id", s_gid, 2);
    drain(200);

    // Reset while requester 3 waits on the serializer.
    check_stream = 0; check_gap = 0;
    exp_q.delete();
    add_byte(3, 8'h31, 1'b0);
    add_byte(3, 8'h32, 1'b0);
    add_byte(3, 8'h33, 1'b1);
    add_byte(0, 8'h01, 1'b0);
    add_byte(0, 8'h02, 1'b1);
    drive_inputs();
    wait_for(3, 20, "prereset_start_seen");
    check("prereset_owner", s_gid, 3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ser_cnt = 0;
    drive_inputs();
    tick();
    check_reset_outputs("midwait_reset");
    wait_for(0, 10, "postreset_grant_seen");
    check("postreset_first_owner", s_gid, 0);
    drain(300);

    // Randomized messages against the round-robin model.
    check_stream = 1; check_gap = 1; check_fall = 1;
    ser_rand = 1;
    for (int m = 0; m < 12; m++) begin
      id  = int'($urandom_range(3, 0));
      len = int'($urandom_range(3, 1));
      for (int b = 0; b < len; b++) add_byte(id, 8'($urandom), b == len - 1);
    end
    do_reset();
    build_expected();
    drain(4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte-stream requesters, e.g. the debug echo path, status reporter and command responder on the Arty-A7 UART.
- Round-robin arbitration at message granularity: a granted requester keeps the transmitter until it sends a byte flagged last, or until it stalls past the timeout.
- Drives the serializer's start/data strobe and waits for its done pulse before each next byte.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PACK_SIZE, 8, bits per UART data packet; must match the serializer.
- TIMEOUT_CYCLES, 8680, mid-message stall limit in clk cycles (10 bit times at 868 CLK_PER_BIT); 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*PACK_SIZE  packed bytes; requester i occupies bits [i*PACK_SIZE +: PACK_SIZE]
- req_last  in  NUM_REQ  byte is the final byte of its message
- req_ready  out  NUM_REQ  per-requester byte accepted (handshake when valid&&ready)
- tx_start  out  1  one-cycle start strobe to the serializer
- tx_data  out  PACK_SIZE  byte to serialize; held stable from the tx_start cycle until tx_done
- tx_active  in  1  serializer busy
- tx_done  in  1  one-cycle pulse at the end of the stop bit
- grant_valid  out  1  a requester currently owns the transmitter
- grant_id  out  max(1,$clog2(NUM_REQ))  index of the owner; valid only when grant_valid=1
- timeout_err  out  1  one-cycle pulse when a grant is revoked by the timeout

Behaviour:
- Reset values: req_ready=0, tx_start=0, tx_data=0, grant_valid=0, grant_id=0, timeout_err=0, stall counter=0, last_r=0, state=IDLE.
- Reset sets the priority pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation: return to IDLE on the next edge and drop grant_valid. A byte already handed to the serializer completes under the serializer's own reset; it is neither replayed nor reported.
- States: IDLE, SEND, WAIT.
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from last_grant+1 with wrap-around.
  - Register grant_id=winner and grant_valid=1 next edge; go to SEND. Arbitration costs exactly 1 cycle.
  - If no req_valid is set, stay in IDLE.
- SEND:
  - req_ready[grant_id] = (state==SEND) && !tx_active. This is combinational, with no dependence on req_valid. All other req_ready bits are 0 in every state.
  - On handshake: tx_data<=byte, tx_start<=1 for exactly one cycle (tx_start rises the cycle after handshake), last_r<=req_last[grant_id], stall counter<=0, go to WAIT.
  - No handshake: stall counter increments.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 with no handshake that cycle:
    - pulse timeout_err;
    - grant_valid<=0, last_grant<=grant_id;
    - go to IDLE.
  - The stall counter is width $clog2(TIMEOUT_CYCLES+1) and saturates; it never wraps.
- WAIT:
  - Ignore req_valid and hold tx_data.
  - On tx_done with last_r=1: grant_valid<=0, last_grant<=grant_id, go to IDLE.
  - On tx_done with last_r=0: go to SEND; the stall counter restarts from 0.
  - tx_done seen while tx_start is high is ignored, because it belongs to the previous byte.
- Fairness: a requester that just finished a message gets lowest priority. A single active requester is re-granted after 1 idle cycle.
- Simultaneous events:
  - A requester dropping req_valid while ungranted simply loses arbitration.
  - req_last on a byte in the same cycle as handshake is captured with that byte.
  - A requester that raises req_valid before its ready is asserted is served when ready asserts; the byte is not lost.
- Single-byte message: handshake with req_last=1 gives the sequence IDLE→SEND→WAIT→IDLE.

Test Plan:
- Single message: requester 2 sends 0x48,0x69 (last on 0x69) with a serializer model (done 10 cycles after start) → tx_start pulses twice; tx_data is 0x48 then 0x69; grant_id=2 throughout; grant_valid drops the cycle after the second tx_done.
- Contention: requesters 0,1,3 each hold a 2-byte message from reset → grants in order 0,1,3; no interleaving of bytes between messages; 1 idle cycle between grants.
- Fairness wrap: last_grant=3, requesters 0 and 3 both valid → 0 is granted. Then requester 3 re-requests while 0 is still sending → 3 is granted next.
- Timeout with TIMEOUT_CYCLES=20: requester 1 sends 0xAA (not last), then drops valid → timeout_err pulses exactly 20 cycles after entering SEND; grant_valid=0; pending requester 2 is granted next.
- Busy serializer: tx_active held high in SEND → req_ready=0 and no tx_start; when tx_active falls, ready rises that same cycle.
- Reset mid-WAIT: assert rst for 1 cycle → all outputs return to reset values the next cycle; requester 0 is granted first afterwards.
